// File: rtl/vc_ingress_shaper.sv
// Per-VC holding buffers with a pause/resume/error FSM per VC and a
// round-robin issue stage feeding the QoS demux.
module vc_ingress_shaper #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int HOLD_DEPTH     = 2,
    parameter int DROP_CNT_BITS  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    enb,
    input  logic                                    in_valid,
    input  logic [BUF_WIDTH:0]                      in_data,
    input  logic [$clog2(QUEUE_QUANTITY)-1:0]       in_vc,
    output logic                                    in_ready,
    input  logic [QUEUE_QUANTITY-1:0]               pausa,
    input  logic [QUEUE_QUANTITY-1:0]               continuar,
    input  logic [QUEUE_QUANTITY-1:0]               error_full,
    output logic                                    wr_valid,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]       vc_id,
    output logic [BUF_WIDTH:0]                      data_word,
    output logic [QUEUE_QUANTITY*DROP_CNT_BITS-1:0] drop_count
);

    localparam int VW = $clog2(QUEUE_QUANTITY);
    localparam int DW = BUF_WIDTH + 1;
    localparam int PW = $clog2(HOLD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(HOLD_DEPTH);
    localparam logic [DROP_CNT_BITS-1:0] DMAX = '1;

    typedef enum logic [1:0] {RUN, PAUSED, ERROR} state_t;

    state_t                   state_q [QUEUE_QUANTITY];
    state_t                   state_d [QUEUE_QUANTITY];
    logic [DW-1:0]            mem     [QUEUE_QUANTITY][HOLD_DEPTH];
    logic [PW-1:0]            rd      [QUEUE_QUANTITY];
    logic [PW-1:0]            wr      [QUEUE_QUANTITY];
    logic [CW-1:0]            cnt     [QUEUE_QUANTITY];
    logic [DROP_CNT_BITS-1:0] drop    [QUEUE_QUANTITY];

    logic [QUEUE_QUANTITY-1:0] flush;
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [QUEUE_QUANTITY-1:0] push;
    logic [QUEUE_QUANTITY-1:0] pop;
    logic [VW-1:0]             last_grant;
    logic [VW-1:0]             grant;
    logic [VW-1:0]             idx;
    logic                      grant_valid;
    logic                      accept;
    logic                      discard;
    logic                      store;

    assign in_ready = enb && !rst &&
                      (state_q[in_vc] == ERROR || cnt[in_vc] < FULL);
    assign accept   = in_valid && in_ready;
    // Words aimed at a VC in (or entering) ERROR are counted, never stored.
    assign discard  = accept &&
                      (state_q[in_vc] == ERROR || error_full[in_vc]);
    assign store    = accept && !discard;

    always_comb begin
        for (int v = 0; v < QUEUE_QUANTITY; v++) begin
            state_d[v] = state_q[v];
            flush[v]   = 1'b0;
            if (error_full[v]) begin
                state_d[v] = ERROR;
                flush[v]   = 1'b1;
            end else if (pausa[v]) begin
                if (state_q[v] == RUN) state_d[v] = PAUSED;
            end else if (continuar[v]) begin
                state_d[v] = RUN;
            end
            eligible[v] = (state_q[v] == RUN) && !pausa[v] &&
                          !error_full[v] && (cnt[v] != '0);
        end
    end

    // Round-robin search starting one past the last granted VC.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int i = 1; i <= QUEUE_QUANTITY; i++) begin
            idx = last_grant + VW'(i);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < QUEUE_QUANTITY; v++) begin
            push[v] = store && (in_vc == VW'(v));
            pop[v]  = grant_valid && (grant == VW'(v));
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[in_vc][wr[in_vc]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < QUEUE_QUANTITY; v++) begin
                state_q[v] <= RUN;
                rd[v]      <= '0;
                wr[v]      <= '0;
                cnt[v]     <= '0;
                drop[v]    <= '0;
            end
            last_grant <= VW'(QUEUE_QUANTITY - 1);
            wr_valid   <= 1'b0;
            vc_id      <= '0;
            data_word  <= '0;
        end else if (enb) begin
            wr_valid <= grant_valid;
            if (grant_valid) begin
                vc_id      <= grant;
                data_word  <= mem[grant][rd[grant]];
                last_grant <= grant;
            end
            if (discard && drop[in_vc] != DMAX)
                drop[in_vc] <= drop[in_vc] + 1'b1;
            for (int v = 0; v < QUEUE_QUANTITY; v++) begin
                state_q[v] <= state_d[v];
                if (flush[v]) begin
                    cnt[v] <= '0;
                    rd[v]  <= wr[v];
                end else begin
                    if (push[v]) wr[v] <= wr[v] + 1'b1;
                    if (pop[v])  rd[v] <= rd[v] + 1'b1;
                    cnt[v] <= cnt[v] + CW'(push[v]) - CW'(pop[v]);
                end
            end
        end else begin
            wr_valid <= 1'b0;
        end
    end

    for (genvar v = 0; v < QUEUE_QUANTITY; v++) begin : g_drop
        assign drop_count[v*DROP_CNT_BITS +: DROP_CNT_BITS] = drop[v];
    end

endmodule

// File: doc/vc_ingress_shaper.md
# vc_ingress_shaper

Ingress stage directly upstream of the QoS block. Accepts a single tagged word stream (`in_data`, `in_vc`) and holds each word in a small per-virtual-channel buffer. Issues at most one word per cycle as `vc_id`/`data_word` into the QoS demux. Issue respects the QoS flow-control outputs `pausa`, `continuar` and `error_full` through one state machine per VC, so a paused VC never blocks traffic on the other VCs.

## Interface
- `QUEUE_QUANTITY`, 4, number of virtual channels; must be a power of two ≥ 2.
- `BUF_WIDTH`, 3, data words are `BUF_WIDTH+1` bits wide, matching the QoS `data_word`.
- `HOLD_DEPTH`, 2, entries per VC holding buffer; must be a power of two ≥ 2.
- `DROP_CNT_BITS`, 8, width of each per-VC drop counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `enb`  in  1  block enable; when low, all state freezes.
- `in_valid`  in  1  upstream word present.
- `in_data`  in  BUF_WIDTH+1  upstream word.
- `in_vc`  in  clog2(QUEUE_QUANTITY)  target VC of `in_data`.
- `in_ready`  out  1  combinational; the word transfers when `in_valid && in_ready` at a clock edge.
- `pausa`  in  QUEUE_QUANTITY  per-VC pause request from QoS.
- `continuar`  in  QUEUE_QUANTITY  per-VC resume request from QoS.
- `error_full`  in  QUEUE_QUANTITY  per-VC overflow error from QoS.
- `wr_valid`  out  1  registered; `vc_id`/`data_word` hold a valid word this cycle.
- `vc_id`  out  clog2(QUEUE_QUANTITY)  registered; VC of the issued word.
- `data_word`  out  BUF_WIDTH+1  registered; issued word.
- `drop_count`  out  QUEUE_QUANTITY*DROP_CNT_BITS  per-VC saturating drop counters; VC v occupies bits [v*DROP_CNT_BITS +: DROP_CNT_BITS].

## Operation
- Holding buffers: each VC has a circular buffer of `HOLD_DEPTH` entries with read pointer, write pointer and a count of `clog2(HOLD_DEPTH)+1` bits. Pointers wrap modulo `HOLD_DEPTH`.
- Per-VC FSM states: RUN, PAUSED, ERROR.
- Transition priority, evaluated per VC every enabled cycle: `error_full[v]` first, then `pausa[v]`, then `continuar[v]`.
  - Any state with `error_full[v]` high → ERROR. On entry, the VC buffer is flushed: count=0, rd=wr.
  - RUN with `pausa[v]` high → PAUSED.
  - PAUSED or ERROR with `continuar[v]` high and no higher-priority input → RUN.
  - `pausa` and `continuar` both high in the same cycle: `pausa` wins.
- Input accept rule:
  - `in_ready = enb && !rst && (state[in_vc]==ERROR || count[in_vc] < HOLD_DEPTH)`.
  - A word accepted for a VC in ERROR (or for a VC whose `error_full` is high that cycle) is discarded. Its drop counter increments and saturates at all-ones.
- Issue eligibility: VC v is eligible when `state[v]==RUN && !pausa[v] && !error_full[v] && count[v]>0`.
  - The current-cycle `pausa` and `error_full` values mask issue, so no word is issued in the cycle a pause is raised.
- Arbitration: plain round-robin over eligible VCs.
  - The search starts at `last_grant+1` and wraps.
  - `last_grant` updates only when a word is issued.
- Issue action: the head entry of the granted VC is registered into `data_word`/`vc_id` with `wr_valid=1`, and that VC's read pointer advances. With no eligible VC, `wr_valid=0` and `vc_id`/`data_word` hold their previous values.
- Accept and issue on the same VC in the same cycle are both permitted; the count is unchanged.
- Word order within a VC is strictly preserved. No word is ever duplicated.

## Timing
- Reset values:
  - all FSMs RUN; all buffers empty.
  - `last_grant` = QUEUE_QUANTITY-1, so the first grant search starts at VC 0.
  - `wr_valid`=0, `vc_id`=0, `data_word`=0, all `drop_count`=0.
  - `in_ready`=0 while `rst` is high.
- Latency: a word accepted at edge N into an empty, eligible, uncontested VC appears on `wr_valid`/`data_word` after edge N+1 (one cycle).
- Throughput: one issued word per cycle while any VC is eligible.
- `pausa[v]` high at edge N: no VC v issue is registered at edge N, and VC v is in PAUSED from edge N onward.
- `continuar[v]` at edge N: VC v may issue at edge N+1.
- `enb` low: pointers, counters, FSMs and `last_grant` hold. `wr_valid` is registered to 0. `in_ready`=0.
- `rst` asserted mid-operation: all buffered words are discarded at that edge, and outputs take their reset values after it.

## Test plan
- Reset, then send 0x5 on VC0 and 0x9 on VC0 back-to-back → `wr_valid` pulses on two consecutive cycles starting one cycle after the first accept; `vc_id`=0; data 0x5 then 0x9.
- Fill VC1 with 2 words while `pausa[1]`=1 → third VC1 word sees `in_ready`=0. Traffic on VC2 still issues. Pulse `continuar[1]` → the two VC1 words issue in order on the next two cycles.
- Preload one word each on VC0–VC3, all RUN → issue order is 0,1,2,3 on four consecutive cycles. A second round starts again at VC0.
- Hold 2 words in VC3 and assert `error_full[3]` for one cycle → buffer flushed, nothing issued on VC3. Three more VC3 words are accepted and `drop_count[3]` reads 3. After `continuar[3]`, new VC3 words issue normally.
- Assert `pausa[2]` and `continuar[2]` together → VC2 goes to PAUSED. Drop saturation: with `DROP_CNT_BITS`=8, 300 drops on VC0 → `drop_count[0]`=255.
- Deassert `enb` with words pending → `wr_valid`=0 and all state held. Reassert `enb` → issue resumes with the same VC order. Assert `rst` mid-stream → the next cycle shows all outputs at their reset values.
